pixel_sink: RTL

- Receiving end of the (x, y) pixel-coordinate stream produced by the drawing generators (tile outlines, blank-tile stripes, digits).
- Buffers incoming pixels in a small FIFO under a valid/ready handshake.
- Clips pixels that fall outside the 160x120 screen, then issues one-cycle plot strobes with x/y/colour to the VGA adapter's write port.
- Sits between the drawing-generator mux and the VGA adapter; the control FSM can stall it during board updates.

---
 rtl/pixel_sink_pkg.sv | 28 ++
 rtl/pixel_fifo.sv | 65 ++++++
 rtl/pixel_sink.sv | 89 ++++++++
 3 files changed

// File: rtl/pixel_sink_pkg.sv
// Shared screen geometry, coordinate widths, colours and the packed pixel
// record used by the pixel sink and its FIFO.
package pixel_sink_pkg;

    localparam int unsigned SCREEN_W = 32'd160;
    localparam int unsigned SCREEN_H = 32'd120;
    localparam int unsigned XW       = 32'd8;
    localparam int unsigned YW       = 32'd7;
    localparam int unsigned CW       = 32'd3;

    localparam logic [CW-1:0] BLACK = 3'b000;
    localparam logic [CW-1:0] WHITE = 3'b111;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] colour;
    } pixel_t;

    // Unsigned test of a coordinate pair against the exclusive screen limits.
    function automatic logic on_screen(input logic [XW-1:0] px,
                                       input logic [YW-1:0] py,
                                       input int unsigned   x_max,
                                       input int unsigned   y_max);
        return (32'(px) < x_max) && (32'(py) < y_max);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with a count one bit wider than the pointers, so full and
// empty are distinct without sacrificing a slot.
module pixel_fifo
    import pixel_sink_pkg::*;
#(
    parameter int unsigned DEPTH = 32'd4,
    parameter int unsigned WIDTH = 32'd18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pixel_sink.sv
// Buffers generator pixels, clips anything off the 160x120 screen and issues
// one-cycle plot strobes to the VGA adapter write port.
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int unsigned DEPTH = 32'd4,
    parameter int unsigned X_MAX = SCREEN_W,
    parameter int unsigned Y_MAX = SCREEN_H,
    parameter int unsigned CW    = 32'd3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_x,
    input  logic [6:0]    in_y,
    input  logic [CW-1:0] in_colour,
    output logic          in_ready,
    input  logic          out_stall,
    output logic          plot,
    output logic [7:0]    x,
    output logic [6:0]    y,
    output logic [CW-1:0] colour,
    output logic          busy,
    output logic [15:0]   plot_count,
    output logic [15:0]   clip_count
);

    localparam int unsigned PW = XW + YW + CW;
    localparam int unsigned AW = $clog2(DEPTH);

    logic [PW-1:0] wdata_s;
    logic [PW-1:0] rdata_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic [AW:0]   count_s;
    logic [7:0]    head_x_s;
    logic [6:0]    head_y_s;
    logic [CW-1:0] head_c_s;

    assign wdata_s  = {in_x, in_y, in_colour};
    assign head_x_s = rdata_s[PW-1 -: 8];
    assign head_y_s = rdata_s[CW+6 -: 7];
    assign head_c_s = rdata_s[CW-1:0];
    assign pop_s    = ~empty_s & ~out_stall;
    assign in_ready = ~full_s;
    assign busy     = (count_s != {(AW+1){1'b0}}) | plot;

    pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (rdata_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Output stage: coordinates follow every popped pixel, plot only when on screen.
    always_ff @(posedge clk) begin
        if (reset) begin
            plot       <= 1'b0;
            x          <= 8'd0;
            y          <= 7'd0;
            colour     <= {CW{1'b0}};
            plot_count <= 16'd0;
            clip_count <= 16'd0;
        end else if (pop_s) begin
            x      <= head_x_s;
            y      <= head_y_s;
            colour <= head_c_s;
            if (on_screen(head_x_s, head_y_s, X_MAX, Y_MAX)) begin
                plot       <= 1'b1;
                plot_count <= plot_count + 16'd1;
            end else begin
                plot       <= 1'b0;
                clip_count <= clip_count + 16'd1;
            end
        end else begin
            plot <= 1'b0;
        end
    end

endmodule
